// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
//    ID/EX pipeline register with load-use hazard detection for a 5-stage RV32I core.
//    The stage captures decoded operands, control and the ID-stage forwarding selects
//    for the EX operand muxes. When a load in EX targets a register read by the
//    instruction in ID, it holds PC and IF/ID for one cycle and places a bubble in EX.
//    A branch flush from EX and a memory-stall freeze are also handled here.
//
// Ports
//    clk, rst_n              core clock (rising edge), asynchronous active-low reset
//    ID_*                    decoded instruction presented by the ID stage
//    ForwardA_in/B_in        forwarding selects for rs1/rs2 (00 RF, 10 EX, 01 MEM)
//    EX_flush                taken branch/jump resolved in EX
//    MEM_stall               data memory busy; the whole front end freezes
//    PC_wr_en, IFID_wr_en    front-end advance enables
//    load_use_stall          bubble being inserted this cycle
//    EX_*                    registered copies presented to the EX stage
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the perf_stall_cycles and
// perf_flush_count counter outputs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal flow; a load-use hazard may insert a bubble
// BUBBLE | bubble sits in EX; ID instruction is being re-presented
module id_ex_hazard_stage #(
   parameter int REG_DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH         = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ID_valid,
   input  logic [REG_DATA_WIDTH-1:0]     ID_PC,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
   input  logic                          ID_Rs1_used,
   input  logic                          ID_Rs2_used,
   input  logic [REG_DATA_WIDTH-1:0]     ID_Rs1_data,
   input  logic [REG_DATA_WIDTH-1:0]     ID_Rs2_data,
   input  logic [REG_DATA_WIDTH-1:0]     ID_Imm,
   input  logic [CTRL_WIDTH-1:0]         ID_ctrl,
   input  logic                          ID_RegFile_wr_en,
   input  logic                          ID_MemRd_en,
   input  logic [1:0]                    ForwardA_in,
   input  logic [1:0]                    ForwardB_in,
   input  logic                          EX_flush,
   input  logic                          MEM_stall,
   output logic                          PC_wr_en,
   output logic                          IFID_wr_en,
   output logic                          load_use_stall,
   output logic                          EX_valid,
   output logic [REG_DATA_WIDTH-1:0]     EX_PC,
   output logic [REG_DATA_WIDTH-1:0]     EX_Rs1_data,
   output logic [REG_DATA_WIDTH-1:0]     EX_Rs2_data,
   output logic [REG_DATA_WIDTH-1:0]     EX_Imm,
   output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
   output logic [CTRL_WIDTH-1:0]         EX_ctrl,
   output logic                          EX_RegFile_wr_en,
   output logic                          EX_MemRd_en,
   output logic [1:0]                    EX_ForwardA,
   output logic [1:0]                    EX_ForwardB
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_stall_cycles,
   output logic [31:0]                   perf_flush_count
`endif
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

   state_t                          state_q, state_d;
   logic                            ex_valid_q, ex_valid_d;
   logic [REG_DATA_WIDTH-1:0]       ex_pc_q, ex_pc_d;
   logic [REG_DATA_WIDTH-1:0]       ex_rs1_data_q, ex_rs1_data_d;
   logic [REG_DATA_WIDTH-1:0]       ex_rs2_data_q, ex_rs2_data_d;
   logic [REG_DATA_WIDTH-1:0]       ex_imm_q, ex_imm_d;
   logic [REGFILE_ADDR_WIDTH-1:0]   ex_rd_addr_q, ex_rd_addr_d;
   logic [CTRL_WIDTH-1:0]           ex_ctrl_q, ex_ctrl_d;
   logic                            ex_wr_en_q, ex_wr_en_d;
   logic                            ex_mem_rd_q, ex_mem_rd_d;
   logic [1:0]                      ex_fwd_a_q, ex_fwd_a_d;
   logic [1:0]                      ex_fwd_b_q, ex_fwd_b_d;
   logic                            hazard;
   logic                            stall_bubble;

   // A bubble in EX (ex_valid_q=0) can never trigger a hazard, which is what
   // keeps the stall to a single cycle.
   always_comb begin
      hazard = ex_valid_q & ex_mem_rd_q & (ex_rd_addr_q != '0) & ID_valid &
               ((ID_Rs1_used & (ex_rd_addr_q == ID_Rs1_addr)) |
                (ID_Rs2_used & (ex_rd_addr_q == ID_Rs2_addr)));
      stall_bubble   = hazard & ~EX_flush;
      load_use_stall = stall_bubble;
      PC_wr_en       = ~(stall_bubble | MEM_stall) | EX_flush;
      IFID_wr_en     = ~(stall_bubble | MEM_stall) | EX_flush;
   end

   always_comb begin
      state_d       = state_q;
      ex_valid_d    = ex_valid_q;
      ex_pc_d       = ex_pc_q;
      ex_rs1_data_d = ex_rs1_data_q;
      ex_rs2_data_d = ex_rs2_data_q;
      ex_imm_d      = ex_imm_q;
      ex_rd_addr_d  = ex_rd_addr_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_wr_en_d    = ex_wr_en_q;
      ex_mem_rd_d   = ex_mem_rd_q;
      ex_fwd_a_d    = ex_fwd_a_q;
      ex_fwd_b_d    = ex_fwd_b_q;

      if (EX_flush) begin
         // flush wins over a memory freeze so the killed instruction cannot linger
         state_d     = ST_RUN;
         ex_valid_d  = 1'b0;
         ex_wr_en_d  = 1'b0;
         ex_mem_rd_d = 1'b0;
         ex_fwd_a_d  = 2'b00;
         ex_fwd_b_d  = 2'b00;
      end else if (MEM_stall) begin
         state_d = state_q;
      end else if (stall_bubble) begin
         // data fields keep their old contents; they are don't-care in a bubble
         state_d     = ST_BUBBLE;
         ex_valid_d  = 1'b0;
         ex_wr_en_d  = 1'b0;
         ex_mem_rd_d = 1'b0;
         ex_fwd_a_d  = 2'b00;
         ex_fwd_b_d  = 2'b00;
      end else begin
         state_d       = ST_RUN;
         ex_valid_d    = ID_valid;
         ex_pc_d       = ID_PC;
         ex_rs1_data_d = ID_Rs1_data;
         ex_rs2_data_d = ID_Rs2_data;
         ex_imm_d      = ID_Imm;
         ex_rd_addr_d  = ID_Rd_addr;
         ex_ctrl_d     = ID_ctrl;
         ex_wr_en_d    = ID_RegFile_wr_en & ID_valid;
         ex_mem_rd_d   = ID_MemRd_en & ID_valid;
         ex_fwd_a_d    = ForwardA_in;
         ex_fwd_b_d    = ForwardB_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_rd_addr_q  <= '0;
         ex_ctrl_q     <= '0;
         ex_wr_en_q    <= 1'b0;
         ex_mem_rd_q   <= 1'b0;
         ex_fwd_a_q    <= 2'b00;
         ex_fwd_b_q    <= 2'b00;
      end else begin
         state_q       <= state_d;
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_rd_addr_q  <= ex_rd_addr_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_wr_en_q    <= ex_wr_en_d;
         ex_mem_rd_q   <= ex_mem_rd_d;
         ex_fwd_a_q    <= ex_fwd_a_d;
         ex_fwd_b_q    <= ex_fwd_b_d;
      end
   end

   assign EX_valid         = ex_valid_q;
   assign EX_PC            = ex_pc_q;
   assign EX_Rs1_data      = ex_rs1_data_q;
   assign EX_Rs2_data      = ex_rs2_data_q;
   assign EX_Imm           = ex_imm_q;
   assign EX_Rd_addr       = ex_rd_addr_q;
   assign EX_ctrl          = ex_ctrl_q;
   assign EX_RegFile_wr_en = ex_wr_en_q;
   assign EX_MemRd_en      = ex_mem_rd_q;
   assign EX_ForwardA      = ex_fwd_a_q;
   assign EX_ForwardB      = ex_fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // both counters wrap naturally at 2^32
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall_bubble};
      flush_cnt_d = flush_cnt_q + {31'd0, EX_flush};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ID_valid = 1'b0;
   logic [31:0] ID_PC = '0;
   logic [4:0]  ID_Rs1_addr = '0, ID_Rs2_addr = '0, ID_Rd_addr = '0;
   logic        ID_Rs1_used = 1'b0, ID_Rs2_used = 1'b0;
   logic [31:0] ID_Rs1_data = '0, ID_Rs2_data = '0, ID_Imm = '0;
   logic [15:0] ID_ctrl = '0;
   logic        ID_RegFile_wr_en = 1'b0, ID_MemRd_en = 1'b0;
   logic [1:0]  ForwardA_in = '0, ForwardB_in = '0;
   logic        EX_flush = 1'b0, MEM_stall = 1'b0;
   logic        PC_wr_en, IFID_wr_en, load_use_stall, EX_valid;
   logic [31:0] EX_PC, EX_Rs1_data, EX_Rs2_data, EX_Imm;
   logic [4:0]  EX_Rd_addr;
   logic [15:0] EX_ctrl;
   logic        EX_RegFile_wr_en, EX_MemRd_en;
   logic [1:0]  EX_ForwardA, EX_ForwardB;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] pc_gen = 32'h0000_1000;
   logic [31:0] saved_pc;

   always #5 clk = ~clk;

   id_ex_hazard_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ID_valid(ID_valid), .ID_PC(ID_PC),
      .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
      .ID_Rs1_used(ID_Rs1_used), .ID_Rs2_used(ID_Rs2_used),
      .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data), .ID_Imm(ID_Imm),
      .ID_ctrl(ID_ctrl), .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_MemRd_en(ID_MemRd_en),
      .ForwardA_in(ForwardA_in), .ForwardB_in(ForwardB_in),
      .EX_flush(EX_flush), .MEM_stall(MEM_stall),
      .PC_wr_en(PC_wr_en), .IFID_wr_en(IFID_wr_en), .load_use_stall(load_use_stall),
      .EX_valid(EX_valid), .EX_PC(EX_PC), .EX_Rs1_data(EX_Rs1_data),
      .EX_Rs2_data(EX_Rs2_data), .EX_Imm(EX_Imm), .EX_Rd_addr(EX_Rd_addr),
      .EX_ctrl(EX_ctrl), .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_MemRd_en(EX_MemRd_en),
      .EX_ForwardA(EX_ForwardA), .EX_ForwardB(EX_ForwardB)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the EX stage contents: either empty, or a copy of the ID instruction.
   logic        m_valid = 1'b0, m_wr = 1'b0, m_ld = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [31:0] m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
   logic [15:0] m_ctrl = '0;
   logic [1:0]  m_fa = '0, m_fb = '0;

   function automatic logic m_load_use();
      logic reads_rd;
      reads_rd = (ID_Rs1_used && ID_Rs1_addr == m_rd) || (ID_Rs2_used && ID_Rs2_addr == m_rd);
      return m_valid && m_ld && m_rd != 0 && ID_valid && reads_rd && !EX_flush;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0; m_wr <= 1'b0; m_ld <= 1'b0; m_fa <= '0; m_fb <= '0;
      end else if (EX_flush || (!MEM_stall && m_load_use())) begin
         m_valid <= 1'b0; m_wr <= 1'b0; m_ld <= 1'b0; m_fa <= '0; m_fb <= '0;
      end else if (!MEM_stall) begin
         m_valid <= ID_valid;
         m_wr    <= ID_valid && ID_RegFile_wr_en;
         m_ld    <= ID_valid && ID_MemRd_en;
         m_rd    <= ID_Rd_addr;
         m_pc    <= ID_PC; m_d1 <= ID_Rs1_data; m_d2 <= ID_Rs2_data;
         m_imm   <= ID_Imm; m_ctrl <= ID_ctrl;
         m_fa    <= ForwardA_in; m_fb <= ForwardB_in;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_stall", {31'd0, load_use_stall}, {31'd0, m_load_use()});
         chk("cyc_pc_wr", {31'd0, PC_wr_en}, {31'd0, !(m_load_use() || MEM_stall) || EX_flush});
         chk("cyc_ifid_wr", {31'd0, IFID_wr_en}, {31'd0, !(m_load_use() || MEM_stall) || EX_flush});
         chk("cyc_valid", {31'd0, EX_valid}, {31'd0, m_valid});
         chk("cyc_wr", {31'd0, EX_RegFile_wr_en}, {31'd0, m_wr});
         chk("cyc_memrd", {31'd0, EX_MemRd_en}, {31'd0, m_ld});
         chk("cyc_fwd", {28'd0, EX_ForwardA, EX_ForwardB}, {28'd0, m_fa, m_fb});
         if (m_valid) begin
            chk("cyc_rd", {27'd0, EX_Rd_addr}, {27'd0, m_rd});
            chk("cyc_pc", EX_PC, m_pc);
            chk("cyc_d1", EX_Rs1_data, m_d1);
            chk("cyc_d2", EX_Rs2_data, m_d2);
            chk("cyc_imm", EX_Imm, m_imm);
            chk("cyc_ctrl", {16'd0, EX_ctrl}, {16'd0, m_ctrl});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic wr, input logic ld, input logic [1:0] fa,
                        input logic [1:0] fb);
      ID_valid = v; ID_Rd_addr = rd; ID_Rs1_addr = rs1; ID_Rs2_addr = rs2;
      ID_Rs1_used = u1; ID_Rs2_used = u2; ID_RegFile_wr_en = wr; ID_MemRd_en = ld;
      ForwardA_in = fa; ForwardB_in = fb;
      ID_PC = pc_gen; pc_gen = pc_gen + 32'd4;
      ID_Rs1_data = $urandom; ID_Rs2_data = $urandom; ID_Imm = $urandom;
      ID_ctrl = 16'($urandom);
      #1;
   endtask

   initial begin
      // reset
      #12;
      chk("rst_valid", {31'd0, EX_valid}, 32'd0);
      chk("rst_fwd", {30'd0, EX_ForwardA}, 32'd0);
      rst_n = 1'b1;
      step();

      // T1: lw x5 then add x6,x5,x1
      instr(1, 5, 2, 0, 1, 0, 1, 1, 2'b00, 2'b00);
      step();
      instr(1, 6, 5, 1, 1, 1, 1, 0, 2'b00, 2'b00);
      chk("t1_stall", {31'd0, load_use_stall}, 32'd1);
      chk("t1_pc_wr", {31'd0, PC_wr_en}, 32'd0);
      step();
      chk("t1_bubble", {31'd0, EX_valid}, 32'd0);
      ForwardA_in = 2'b01; #1;
      chk("t1_nostall", {31'd0, load_use_stall}, 32'd0);
      chk("t1_pc_wr2", {31'd0, PC_wr_en}, 32'd1);
      saved_pc = ID_PC;
      step();
      chk("t1_valid", {31'd0, EX_valid}, 32'd1);
      chk("t1_rd", {27'd0, EX_Rd_addr}, 32'd6);
      chk("t1_fwda", {30'd0, EX_ForwardA}, 32'd1);
      chk("t1_pc", EX_PC, saved_pc);

      // T2: load to x0 then consumer of x0
      instr(1, 0, 3, 0, 1, 0, 1, 1, 2'b00, 2'b00);
      step();
      instr(1, 6, 0, 0, 1, 1, 1, 0, 2'b00, 2'b10);
      chk("t2_stall", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("t2_valid", {31'd0, EX_valid}, 32'd1);
      chk("t2_fwdb", {30'd0, EX_ForwardB}, 32'd2);

      // T3: load x7, rs2=x7 but not used
      instr(1, 7, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00);
      step();
      instr(1, 8, 3, 7, 1, 0, 1, 0, 2'b00, 2'b00);
      chk("t3_stall", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("t3_valid", {31'd0, EX_valid}, 32'd1);
      chk("t3_rd", {27'd0, EX_Rd_addr}, 32'd8);

      // T4: MEM_stall for 3 cycles with rd=9 in EX
      instr(1, 9, 1, 2, 1, 1, 1, 0, 2'b10, 2'b01);
      saved_pc = ID_PC;
      step();
      instr(1, 10, 9, 0, 1, 0, 1, 0, 2'b10, 2'b00);
      MEM_stall = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_pc_wr", {31'd0, PC_wr_en}, 32'd0);
         step();
         chk("t4_rd", {27'd0, EX_Rd_addr}, 32'd9);
         chk("t4_pc", EX_PC, saved_pc);
         chk("t4_fwd", {28'd0, EX_ForwardA, EX_ForwardB}, 32'h9);
      end
      MEM_stall = 1'b0; #1;
      step();
      chk("t4_rd10", {27'd0, EX_Rd_addr}, 32'd10);

      // T5: flush with MEM_stall and a load-use hazard
      instr(1, 5, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00);
      step();
      instr(1, 11, 5, 0, 1, 0, 1, 0, 2'b00, 2'b00);
      MEM_stall = 1'b1; EX_flush = 1'b1; #1;
      chk("t5_pc_wr", {31'd0, PC_wr_en}, 32'd1);
      chk("t5_stall", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("t5_valid", {31'd0, EX_valid}, 32'd0);
      MEM_stall = 1'b0; EX_flush = 1'b0;
      instr(1, 12, 5, 0, 1, 0, 1, 0, 2'b00, 2'b00);
      chk("t5_run", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("t5_valid2", {31'd0, EX_valid}, 32'd1);

      // T6: reset in BUBBLE
      instr(1, 5, 1, 0, 1, 0, 1, 1, 2'b10, 2'b10);
      step();
      instr(1, 13, 0, 5, 0, 1, 1, 0, 2'b00, 2'b00);
      chk("t6_stall", {31'd0, load_use_stall}, 32'd1);
      step();
      #1 rst_n = 1'b0; #1;
      chk("t6_valid", {31'd0, EX_valid}, 32'd0);
      chk("t6_fwda", {30'd0, EX_ForwardA}, 32'd0);
      #1 rst_n = 1'b1;
      instr(1, 14, 0, 5, 0, 1, 1, 0, 2'b00, 2'b00);
      chk("t6_run", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("t6_valid2", {31'd0, EX_valid}, 32'd1);

`ifdef HAZARD_PERF_CNT_EN
      chk("perf_rst_s", perf_stall_cycles, 32'd0);
      for (int i = 0; i < 5; i++) begin
         instr(1, 5, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00);
         step();
         instr(1, 6, 5, 0, 1, 0, 1, 0, 2'b00, 2'b00);
         step();
         step();
      end
      EX_flush = 1'b1;
      step();
      step();
      EX_flush = 1'b0;
      step();
      chk("perf_stall", perf_stall_cycles, 32'd5);
      chk("perf_flush", perf_flush_count, 32'd2);
`endif

      instr(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
